// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-producer FIFOs arbitrated round-robin onto a registered CDB; define CDB_LOAD_PRIORITY_EN to give requester 0 absolute priority
module cdb_arbiter #(
    parameter int N_REQ  = 3,
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    localparam int SRC_W = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*TAG_W-1:0]  req_tag,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [DATA_W-1:0]       cdb_data,
    output logic [SRC_W-1:0]        cdb_src
);
    localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int E_W   = TAG_W + DATA_W;

    logic [E_W-1:0]   mem [N_REQ][DEPTH];
    logic [PTR_W-1:0] rd_ptr [N_REQ];
    logic [PTR_W-1:0] wr_ptr [N_REQ];
    logic [CNT_W-1:0] count [N_REQ];
    logic [SRC_W-1:0] rr_ptr, win;
    logic [N_REQ-1:0] cand, rr_cand, push, pop;
    logic             any, rr_upd;
    logic [E_W-1:0]   head;

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cand[i]      = count[i] != '0;
            req_ready[i] = rst_n && count[i] != CNT_W'(DEPTH);
        end
    end

`ifdef CDB_LOAD_PRIORITY_EN
    assign rr_cand = cand & ~N_REQ'(1);
    assign rr_upd  = any && !cand[0];
`else
    assign rr_cand = cand;
    assign rr_upd  = any;
`endif

    // second pass overrides the wrapped pick with the first candidate at or after rr_ptr
    always_comb begin
        win = '0;
        for (int i = N_REQ - 1; i >= 0; i--) if (rr_cand[i]) win = SRC_W'(i);
        for (int i = N_REQ - 1; i >= 0; i--) if (rr_cand[i] && i >= int'(rr_ptr)) win = SRC_W'(i);
`ifdef CDB_LOAD_PRIORITY_EN
        if (cand[0]) win = '0;
`endif
    end

    assign any  = |cand;
    assign push = req_valid & req_ready;
    assign pop  = any ? (N_REQ'(1) << win) : '0;
    assign head = mem[win][rd_ptr[win]];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            if (rr_upd) rr_ptr <= (win == SRC_W'(N_REQ - 1)) ? '0 : win + 1'b1;
            cdb_valid             <= any;
            {cdb_tag, cdb_data}   <= any ? head : '0;
            cdb_src               <= any ? win : '0;
            for (int i = 0; i < N_REQ; i++) begin
                if (push[i]) wr_ptr[i] <= inc(wr_ptr[i]);
                if (pop[i]) rd_ptr[i] <= inc(rd_ptr[i]);
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
        end
    end

    // storage needs no reset: a slot is only read once its count covers it
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++)
            if (push[i]) mem[i][wr_ptr[i]] <= {req_tag[i*TAG_W +: TAG_W], req_data[i*DATA_W +: DATA_W]};
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus against a queue-based model of the CDB arbiter
module tb_cdb_arbiter;
    localparam int N = 3, D = 2, T = 6, W = 32;
`ifdef CDB_LOAD_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n, flush;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*T-1:0] req_tag;
    logic [N*W-1:0] req_data;
    logic           cdb_valid;
    logic [T-1:0]   cdb_tag;
    logic [W-1:0]   cdb_data;
    logic [1:0]     cdb_src;

    cdb_arbiter dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid), .req_tag(req_tag),
        .req_data(req_data), .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, nvalid = 0;
    bit chk_en = 0, rec0 = 0;
    logic [T+W-1:0] q [N][$];
    logic [T-1:0]   seen0 [$];
    int rr = 0;
    logic           ev = 0;
    logic [T-1:0]   et = '0;
    logic [W-1:0]   ed = '0;
    logic [1:0]     es = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model: round-robin over non-empty queues, pushes judged on pre-edge occupancy
    always @(posedge clk) begin
        int w, j;
        logic [N-1:0] pv;
        if (!rst_n || flush) begin
            for (int i = 0; i < N; i++) q[i].delete();
            rr = 0; ev = 0; et = '0; ed = '0; es = '0;
        end else begin
            w = -1;
            if (PRIO && q[0].size() > 0) w = 0;
            for (int k = 0; k < N; k++) begin
                j = (rr + k) % N;
                if (w < 0 && q[j].size() > 0 && !(PRIO && j == 0)) w = j;
            end
            for (int i = 0; i < N; i++) pv[i] = req_valid[i] && q[i].size() < D;
            ev = w >= 0;
            if (w >= 0) begin
                {et, ed} = q[w].pop_front();
                es = 2'(w);
                if (!(PRIO && w == 0)) rr = (w + 1) % N;
            end else begin
                et = '0; ed = '0; es = '0;
            end
            for (int i = 0; i < N; i++)
                if (pv[i]) q[i].push_back({req_tag[i*T +: T], req_data[i*W +: W]});
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] er;
        if (chk_en) begin
            for (int i = 0; i < N; i++) er[i] = rst_n && q[i].size() < D;
            check("req_ready", req_ready, er);
            check("cdb_valid", cdb_valid, ev);
            check("cdb_tag", cdb_tag, et);
            check("cdb_data", cdb_data, ed);
            check("cdb_src", cdb_src, es);
            if (cdb_valid) nvalid++;
            if (rec0 && cdb_valid && cdb_src == 2'd0) seen0.push_back(cdb_tag);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [T-1:0] t, input logic [W-1:0] d);
        req_valid[i] = v;
        req_tag[i*T +: T] = t;
        req_data[i*W +: W] = d;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        int t0, t1, t2;
        logic [N-1:0] rdy;
        bit saw_full0;
        rst_n = 1'b0; flush = 1'b0; req_valid = '1; req_tag = '0; req_data = '0;
        step();
        chk_en = 1;
        check("rst_ready0", req_ready, 0);
        check("rst_valid0", cdb_valid, 0);
        step();
        check("rst_ready1", req_ready, 0);
        check("rst_valid1", cdb_valid, 0);
        rst_n = 1'b1; req_valid = '0;
        #1;
        check("rel_ready", req_ready, 3'b111);
        nvalid = 0;
        repeat (3) step();
        check("rst_no_bcast", nvalid, 0);

        drive(1, 1'b1, 6'd5, 32'hDEAD_BEEF);
        step();
        req_valid = '0;
        step();
        check("single_valid", cdb_valid, 1);
        check("single_tag", cdb_tag, 5);
        check("single_data", cdb_data, 32'hDEAD_BEEF);
        check("single_src", cdb_src, 1);
        step();
        check("single_done", cdb_valid, 0);

        do_flush();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) drive(i, 1'b1, 6'(10 + 3 * r + i), 32'h1000 + 32'(i));
            step();
            req_valid = '0;
            step();
            for (int i = 0; i < N; i++) begin
                check("cont_src", cdb_src, i);
                check("cont_tag", cdb_tag, 10 + 3 * r + i);
                step();
            end
        end

        do_flush();
        t0 = 0; t1 = 0;
        for (int c = 0; c < 6; c++) begin
            if (c >= 2) begin
                check("stream_valid", cdb_valid, 1);
                check("stream_src", cdb_src, PRIO ? 0 : c % 2);
            end
            rdy = req_ready;
            drive(0, 1'b1, 6'(t0), 32'h2000 + 32'(t0));
            drive(1, 1'b1, 6'(20 + t1), 32'h3000 + 32'(t1));
            step();
            if (rdy[0]) t0++;
            if (rdy[1]) t1++;
        end
        req_valid = '0;

        do_flush();
        seen0.delete();
        rec0 = 1; saw_full0 = 0;
        t0 = 1; t1 = 0; t2 = 0;
        for (int c = 0; c < 60 && t0 <= 6; c++) begin
            rdy = req_ready;
            if (!rdy[0]) saw_full0 = 1;
            drive(0, 1'b1, 6'(t0), 32'h4000 + 32'(t0));
            drive(1, 1'b1, 6'(20 + t1 % 20), 32'h5000 + 32'(t1));
            drive(2, 1'b1, 6'(40 + t2 % 20), 32'h6000 + 32'(t2));
            step();
            if (rdy[0]) t0++;
            if (rdy[1]) t1++;
            if (rdy[2]) t2++;
        end
        check("bp_sent", t0, 7);
        req_valid = '0;
        repeat (12) step();
        rec0 = 0;
        check("bp_full0", saw_full0, !PRIO);
        check("bp_count", seen0.size(), 6);
        for (int k = 0; k < 6 && k < seen0.size(); k++) check("bp_order", seen0[k], k + 1);

        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < N; i++) drive(i, 1'b1, 6'(30 + 3 * c + i), 32'h7000);
            step();
        end
        req_valid = '0;
        drive(2, 1'b1, 6'd7, 32'h7777);
        flush = 1'b1;
        step();
        flush = 1'b0; req_valid = '0;
        check("flush_valid", cdb_valid, 0);
        check("flush_ready", req_ready, 3'b111);
        nvalid = 0;
        repeat (6) step();
        check("flush_no_bcast", nvalid, 0);

        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < N; i++) drive(i, 1'b1, 6'(50 + 3 * c + i), 32'h8000);
            step();
        end
        rst_n = 1'b0; req_valid = '1;
        #1;
        check("midrst_ready", req_ready, 0);
        step();
        rst_n = 1'b1; req_valid = '0;
        nvalid = 0;
        repeat (5) step();
        check("midrst_no_bcast", nvalid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
